// File: rtl/haar_stage_evaluator.sv
// Purpose: evaluates one Haar cascade stage over a stored integral window, streaming tree params in.
// Latency: 1 stage word + (5*NUM_RECTS+3) words per tree; each tree resolves 2 cycles after its last word, then a 1-cycle DONE.
// Backpressure: p_ready is high only while loading; p_valid gaps simply stall the word counter.
// Ports: clk/reset (sync, active-high); start + num_trees launch a stage; ii_flat holds the window;
//        p_valid/p_data/p_ready carry the parameter stream; o_busy/o_done/o_pass/o_sum/o_err report status.
module haar_stage_evaluator #(
  parameter int DATA_WIDTH = 12,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_RECTS  = 3,
  parameter int WIN_W      = 10,
  parameter int WIN_H      = 10,
  parameter int TREE_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [TREE_WIDTH-1:0]               num_trees,
  input  logic [WIN_W*WIN_H*DATA_WIDTH-1:0]   ii_flat,
  input  logic                                p_valid,
  input  logic [DATA_WIDTH-1:0]               p_data,
  output logic                                p_ready,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_pass,
  output logic signed [ACC_WIDTH-1:0]         o_sum,
  output logic                                o_err
);

  localparam int NPIX  = WIN_W * WIN_H;
  localparam int WPT   = 5 * NUM_RECTS + 3;
  localparam int CNT_W = $clog2(WPT);
  localparam int RW    = DATA_WIDTH + 2;
  localparam int PW    = DATA_WIDTH + RW;
  // Comparisons and the leaf add run wide enough to hold both the accumulator and a 12-bit word.
  localparam int CW    = (ACC_WIDTH > DATA_WIDTH) ? ACC_WIDTH : DATA_WIDTH;
  localparam int SW    = CW + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPT - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LD_STAGE, LD_TREE, EVAL1, EVAL2, DONE} state_t;
  state_t state_q, state_d;

  // Tree word layout: rect r at [5r..5r+4] = {A,B,C,D,weight}; then node thr, left, right.
  logic [DATA_WIDTH-1:0]        pw_q [WPT];
  logic [CNT_W-1:0]             wcnt_q;
  logic [TREE_WIDTH-1:0]        trees_q;
  logic [TREE_WIDTH-1:0]        tree_cnt_q;
  logic signed [DATA_WIDTH-1:0] stage_thr_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [RW-1:0]         rsum_q [NUM_RECTS];
  logic                         err_q;
  logic                         pass_q;

  logic [DATA_WIDTH-1:0]        corner_c [NUM_RECTS][4];
  logic signed [RW-1:0]         rsum_c [NUM_RECTS];
  logic                         oob_c;
  logic signed [ACC_WIDTH-1:0]  value_c;
  logic                         take_right_c;
  logic [DATA_WIDTH-1:0]        leaf_c;
  logic signed [SW-1:0]         sum_c;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic                         pass_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    p_ready = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = LD_STAGE;
      LD_STAGE: begin
        p_ready = 1'b1;
        if (p_valid) state_d = (trees_q == '0) ? DONE : LD_TREE;
      end
      LD_TREE:  begin
        p_ready = 1'b1;
        if (p_valid && wcnt_q == LAST_WORD) state_d = EVAL1;
      end
      EVAL1:    state_d = EVAL2;
      EVAL2:    state_d = (tree_cnt_q == trees_q - TREE_WIDTH'(1)) ? DONE : LD_TREE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Corner fetch: out-of-window indices read as zero and flag the error.
  always_comb begin
    int idx;
    idx   = 0;
    oob_c = 1'b0;
    for (int r = 0; r < NUM_RECTS; r++) begin
      for (int k = 0; k < 4; k++) begin
        corner_c[r][k] = '0;
        idx = int'(pw_q[5*r+k]);
        if (idx < NPIX) corner_c[r][k] = ii_flat[idx*DATA_WIDTH +: DATA_WIDTH];
        else            oob_c = 1'b1;
      end
      rsum_c[r] = $signed({2'b00, corner_c[r][0]}) - $signed({2'b00, corner_c[r][1]})
                - $signed({2'b00, corner_c[r][2]}) + $signed({2'b00, corner_c[r][3]});
    end
  end

  // Feature value, leaf selection and saturating accumulate.
  always_comb begin
    value_c = '0;
    for (int r = 0; r < NUM_RECTS; r++) begin
      value_c = value_c + ACC_WIDTH'(PW'($signed(pw_q[5*r+4])) * PW'(rsum_q[r]));
    end
    take_right_c = CW'(value_c) >= CW'($signed(pw_q[WPT-3]));
    leaf_c       = take_right_c ? pw_q[WPT-1] : pw_q[WPT-2];
    sum_c        = SW'(acc_q) + SW'($signed(leaf_c));
    if (sum_c > SW'(ACC_MAX))      acc_d = ACC_MAX;
    else if (sum_c < SW'(ACC_MIN)) acc_d = ACC_MIN;
    else                           acc_d = ACC_WIDTH'(sum_c);
    pass_c = CW'(acc_q) >= CW'(stage_thr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WPT; i++) pw_q[i] <= '0;
      for (int r = 0; r < NUM_RECTS; r++) rsum_q[r] <= '0;
      wcnt_q      <= '0;
      trees_q     <= '0;
      tree_cnt_q  <= '0;
      stage_thr_q <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          trees_q    <= num_trees;
          acc_q      <= '0;
          err_q      <= 1'b0;
          pass_q     <= 1'b0;
          wcnt_q     <= '0;
          tree_cnt_q <= '0;
        end
        LD_STAGE: if (p_valid) stage_thr_q <= $signed(p_data);
        LD_TREE: if (p_valid) begin
          pw_q[wcnt_q] <= p_data;
          wcnt_q       <= (wcnt_q == LAST_WORD) ? '0 : wcnt_q + CNT_W'(1);
        end
        EVAL1: begin
          for (int r = 0; r < NUM_RECTS; r++) rsum_q[r] <= rsum_c[r];
          if (oob_c) err_q <= 1'b1;
        end
        EVAL2: begin
          acc_q      <= acc_d;
          tree_cnt_q <= tree_cnt_q + TREE_WIDTH'(1);
        end
        DONE: pass_q <= pass_c;
        default: ;
      endcase
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = (state_q == DONE);
  // The verdict is valid in the DONE cycle itself, then held in pass_q.
  assign o_pass = (state_q == DONE) ? pass_c : pass_q;
  assign o_sum  = acc_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Purpose: self-checking bench for haar_stage_evaluator (default and 8-bit accumulator instances).
// Latency: expectations are queued at stimulus time and popped when o_done fires.
// Backpressure: words are offered with optional one-cycle p_valid gaps.
module tb_haar_stage_evaluator;
  localparam int DW   = 12;
  localparam int NR   = 3;
  localparam int WPT  = 5*NR + 3;
  localparam int NPIX = 100;
  localparam int TW   = 8;

  logic                 clk = 1'b0;
  logic                 reset, start, p_valid;
  logic [TW-1:0]        num_trees;
  logic [NPIX*DW-1:0]   ii_flat;
  logic [DW-1:0]        p_data;
  logic                 p_ready, o_busy, o_done, o_pass, o_err;
  logic signed [23:0]   o_sum;
  logic                 p_ready8, o_busy8, o_done8, o_pass8, o_err8;
  logic signed [7:0]    o_sum8;

  always #5 clk = ~clk;

  haar_stage_evaluator u_dut (
    .clk(clk), .reset(reset), .start(start), .num_trees(num_trees), .ii_flat(ii_flat),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready), .o_busy(o_busy),
    .o_done(o_done), .o_pass(o_pass), .o_sum(o_sum), .o_err(o_err));

  haar_stage_evaluator #(.ACC_WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .num_trees(num_trees), .ii_flat(ii_flat),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready8), .o_busy(o_busy8),
    .o_done(o_done8), .o_pass(o_pass8), .o_sum(o_sum8), .o_err(o_err8));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {longint s24; longint p24; longint s8; longint p8; longint err;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  exp_t last_e;

  logic [DW-1:0] ii [NPIX];
  logic [DW-1:0] tw [$];

  function automatic longint sx(logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint wrapv(longint s, int w);
    longint m = longint'(1) << w;
    longint v = s & (m - 1);
    if (v >= (m >> 1)) v = v - m;
    return v;
  endfunction

  function automatic longint satv(longint s, int w);
    longint mx = (longint'(1) << (w - 1)) - 1;
    if (s > mx) return mx;
    if (s < -mx - 1) return -mx - 1;
    return s;
  endfunction

  task automatic model(input int nt, input logic [DW-1:0] sthr, output exp_t e);
    longint a24 = 0, a8 = 0, s, rs, thr, lf, rt;
    longint px [4];
    int base, idx;
    e.err = 0;
    for (int t = 0; t < nt; t++) begin
      base = t * WPT;
      s = 0;
      for (int r = 0; r < NR; r++) begin
        for (int k = 0; k < 4; k++) begin
          idx = int'(tw[base + 5*r + k]);
          if (idx < NPIX) px[k] = longint'(ii[idx]);
          else begin px[k] = 0; e.err = 1; end
        end
        rs = px[0] - px[1] - px[2] + px[3];
        s = s + sx(tw[base + 5*r + 4]) * rs;
      end
      thr = sx(tw[base + WPT - 3]);
      lf  = sx(tw[base + WPT - 2]);
      rt  = sx(tw[base + WPT - 1]);
      a24 = satv(a24 + ((wrapv(s, 24) >= thr) ? rt : lf), 24);
      a8  = satv(a8  + ((wrapv(s, 8)  >= thr) ? rt : lf), 8);
    end
    e.s24 = a24;
    e.s8  = a8;
    e.p24 = (a24 >= sx(sthr)) ? 1 : 0;
    e.p8  = (a8  >= sx(sthr)) ? 1 : 0;
  endtask

  task automatic pack_ii();
    for (int i = 0; i < NPIX; i++) ii_flat[i*DW +: DW] = ii[i];
  endtask

  task automatic push_tree(input int a, input int b, input int c, input int d, input int w,
                           input int thr, input int lf, input int rt);
    tw.push_back(DW'(a)); tw.push_back(DW'(b)); tw.push_back(DW'(c)); tw.push_back(DW'(d));
    tw.push_back(DW'(w));
    for (int r = 1; r < NR; r++) for (int k = 0; k < 5; k++) tw.push_back('0);
    tw.push_back(DW'(thr)); tw.push_back(DW'(lf)); tw.push_back(DW'(rt));
  endtask

  task automatic push_rand_tree(input int maxw);
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < 4; k++) tw.push_back(DW'($urandom_range(0, NPIX - 1)));
      tw.push_back(DW'(int'($urandom_range(0, 2*maxw)) - maxw));
    end
    tw.push_back(DW'(int'($urandom_range(0, 4000)) - 2000));
    tw.push_back(DW'(int'($urandom_range(0, 1000)) - 500));
    tw.push_back(DW'(int'($urandom_range(0, 1000)) - 500));
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit gap);
    int n;
    if (gap) begin
      p_valid = 1'b0;
      @(posedge clk); #1;
    end
    p_valid = 1'b1;
    p_data  = w;
    n = 0;
    @(negedge clk);
    while (!p_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!p_ready) chk("p_ready_timeout", p_ready, 1);
    @(posedge clk); #1;
    p_valid = 1'b0;
  endtask

  task automatic run_stage(input int nt, input logic [DW-1:0] sthr, input bit gap,
                           input bit busy_start, input bit abort);
    exp_t e;
    int n;
    model(nt, sthr, e);
    if (!abort) sb.push_back(e);
    pack_ii();
    num_trees = TW'(nt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_trees = ~num_trees;
    chk("busy_after_start", o_busy, 1);
    chk("err_clear_on_start", o_err, 0);
    chk("pass_clear_on_start", o_pass, 0);
    send_word(sthr, gap);
    for (int i = 0; i < nt*WPT; i++) begin
      if (busy_start && i == 2) begin
        start = 1'b1;
        num_trees = TW'(nt + 1);
      end
      send_word(tw[i], gap);
      start = 1'b0;
    end
    if (abort) return;
    n = 1;
    @(negedge clk);
    while (!o_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, (nt == 0) ? 1 : 3);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (o_done) begin
      if (sb.size() == 0) chk("unexpected_done", o_done, 0);
      else begin
        mon_e = sb.pop_front();
        chk("sum",   o_sum,   mon_e.s24);
        chk("pass",  o_pass,  mon_e.p24);
        chk("err",   o_err,   mon_e.err);
        chk("done8", o_done8, 1);
        chk("sum8",  o_sum8,  mon_e.s8);
        chk("pass8", o_pass8, mon_e.p8);
        chk("err8",  o_err8,  mon_e.err);
        last_e = mon_e;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_busy"},    o_busy,  0);
    chk({pfx, "_done"},    o_done,  0);
    chk({pfx, "_pass"},    o_pass,  0);
    chk({pfx, "_sum"},     o_sum,   0);
    chk({pfx, "_err"},     o_err,   0);
    chk({pfx, "_p_ready"}, p_ready, 0);
    chk({pfx, "_sum8"},    o_sum8,  0);
  endtask

  initial begin
    logic [DW-1:0] sthr;
    int nt;
    reset = 1'b1; start = 1'b0; p_valid = 1'b0; p_data = '0; num_trees = '0;
    for (int i = 0; i < NPIX; i++) ii[i] = DW'(i);
    pack_ii();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Single tree on an identity window: rect sum 0 >= 0 picks right leaf 7.
    tw.delete();
    push_tree(11, 10, 1, 0, 1, 0, -5, 7);
    run_stage(1, DW'(7), 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", o_sum, 7);
    chk("hold_pass", o_pass, 1);

    // Empty stage.
    tw.delete();
    run_stage(0, DW'(-1), 0, 0, 0);

    // Positive saturation on the 8-bit instance.
    tw.delete();
    for (int t = 0; t < 40; t++) push_tree(0, 0, 0, 0, 0, 0, -5, 100);
    run_stage(40, DW'(0), 0, 0, 0);

    // Negative saturation: value 0 < node thr 1 selects left -100.
    tw.delete();
    for (int t = 0; t < 10; t++) push_tree(0, 0, 0, 0, 0, 1, -100, 100);
    run_stage(10, DW'(0), 0, 0, 0);

    // Out-of-window index.
    tw.delete();
    push_tree(200, 0, 0, 0, 1, 0, -5, 7);
    run_stage(1, DW'(7), 0, 0, 0);

    // Same random stage streamed back-to-back and with gaps plus a stray start.
    for (int i = 0; i < NPIX; i++) ii[i] = DW'($urandom_range(0, 4095));
    tw.delete();
    for (int t = 0; t < 3; t++) push_rand_tree(3);
    sthr = DW'(int'($urandom_range(0, 1000)) - 500);
    run_stage(3, sthr, 0, 0, 0);
    run_stage(3, sthr, 1, 1, 0);

    // Reset while the second tree is in EVAL1.
    for (int i = 0; i < NPIX; i++) ii[i] = DW'(i);
    tw.delete();
    push_tree(11, 10, 1, 0, 1, 0, -5, 7);
    push_tree(11, 10, 1, 0, 1, 0, -5, 7);
    run_stage(2, DW'(7), 0, 0, 1);
    chk("abort_pre_busy", o_busy, 1);
    chk("abort_pre_sum", o_sum, 7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle_outputs("abort");
    tw.delete();
    push_tree(11, 10, 1, 0, 1, 0, -5, 7);
    run_stage(1, DW'(7), 0, 0, 0);

    // Random stages.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < NPIX; i++) ii[i] = DW'($urandom_range(0, 4095));
      nt = int'($urandom_range(1, 4));
      tw.delete();
      for (int t = 0; t < nt; t++) push_rand_tree(5);
      run_stage(nt, DW'(int'($urandom_range(0, 2000)) - 1000), bit'($urandom_range(0, 1)), 0, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
